// File: rtl/cdc_pulse_arbiter.sv
// cdc_pulse_arbiter: round-robin scheduler sharing one fast-to-slow pulse synchronizer,
// spacing grant pulses GAP_CYCLES apart and flagging events dropped on counter saturation.
module cdc_pulse_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int CNT_W      = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               fast_clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_pulse,
  input  logic               ovf_clr,
  output logic               pulse_fast_out,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               pending_any,
  output logic [NUM_REQ-1:0] overflow
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0]     r_cnt [NUM_REQ];
  logic [CNT_W-1:0]     w_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]   r_ovf, w_ovf_set, w_nz;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [ID_W-1:0]      r_ptr, r_gid, w_win;
  logic [GW-1:0]        r_gap;
  logic                 r_pulse, r_pend, w_any, w_gap_done, w_go;

  genvar i;
  generate
    for (i = 0; i < NUM_REQ; i++) begin : g_req
      logic w_inc, w_dec;
      assign w_nz[i]      = r_cnt[i] != '0;
      assign w_inc        = req_pulse[i];
      assign w_dec        = w_go && w_win == ID_W'(i);
      assign w_ovf_set[i] = w_inc && !w_dec && &r_cnt[i];
      assign w_cnt[i]     = (w_inc == w_dec) ? r_cnt[i] :
                            w_dec ? r_cnt[i] - CNT_W'(1) :
                            (&r_cnt[i]) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
    end
  endgenerate

  assign w_any      = |w_nz;
  assign w_gap_done = r_state == GAP && r_gap == '0;
  assign w_go       = enable && w_any && (r_state == IDLE || w_gap_done);
  // Rotate so bit k is the requester k+1 places after the last grant.
  assign w_rot      = {w_nz, w_nz} >> (int'(r_ptr) + 1);

  always_comb begin
    w_win = r_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_win = ID_W'((int'(r_ptr) + 1 + k) % NUM_REQ);
  end

  always_comb begin
    w_next = r_state;
    if (r_state == PULSE) w_next = GAP;
    else if (r_state == IDLE || w_gap_done) w_next = w_go ? PULSE : IDLE;
  end

  always_ff @(posedge fast_clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= '0;
      r_ovf   <= '0;
      r_ptr   <= ID_W'(NUM_REQ - 1);
      r_gid   <= '0;
      r_gap   <= '0;
      r_pulse <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) r_cnt[k] <= w_cnt[k];
      r_ovf   <= w_ovf_set | (r_ovf & ~{NUM_REQ{ovf_clr}});
      r_pulse <= w_go;
      r_pend  <= w_any;
      if (w_go) begin
        r_ptr <= w_win;
        r_gid <= w_win;
      end
      if (r_state == PULSE) r_gap <= GW'(GAP_CYCLES - 1);
      else if (r_state == GAP) r_gap <= r_gap - GW'(1);
    end
  end

  assign pulse_fast_out = r_pulse;
  assign grant_id       = r_gid;
  assign busy           = r_state != IDLE;
  assign pending_any    = r_pend;
  assign overflow       = r_ovf;
endmodule

// File: tb/tb_cdc_pulse_arbiter.sv
// tb_cdc_pulse_arbiter: directed and random stimulus against a timing-rule reference model.
module tb_cdc_pulse_arbiter;
  localparam int N = 4, G = 8, MAXC = 15;
  logic         fast_clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ovf_clr = 1'b0;
  logic [N-1:0] req_pulse = '0;
  logic         pulse_fast_out, busy, pending_any;
  logic [1:0]   grant_id;
  logic [N-1:0] overflow;
  int           checks = 0, passed = 0, cyc = 0;
  int           m_cnt [N];
  logic [N-1:0] m_ovf;
  int           m_ptr, m_last, m_gid;
  logic         m_pulse, m_busy, m_pend;

  cdc_pulse_arbiter #(.NUM_REQ(N), .GAP_CYCLES(G), .CNT_W(4)) dut (
    .fast_clk(fast_clk), .rst_n(rst_n), .enable(enable), .req_pulse(req_pulse),
    .ovf_clr(ovf_clr), .pulse_fast_out(pulse_fast_out), .grant_id(grant_id),
    .busy(busy), .pending_any(pending_any), .overflow(overflow));

  always #5 fast_clk = ~fast_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic model_reset;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_ovf = '0; m_ptr = N - 1; m_last = cyc - 100; m_gid = 0;
    m_pulse = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
  endtask

  // A grant may be issued at any edge at least G+1 edges after the previous one.
  task automatic model_edge(input logic [N-1:0] req, input logic en, input logic clr);
    int w = -1;
    logic any = 1'b0;
    logic [N-1:0] set = '0;
    for (int i = 0; i < N; i++) any |= m_cnt[i] != 0;
    if (en && any && cyc - m_last >= G + 1) begin
      for (int k = 1; k <= N; k++)
        if (w < 0 && m_cnt[(m_ptr + k) % N] != 0) w = (m_ptr + k) % N;
      m_ptr = w; m_last = cyc; m_gid = w;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && w == i) ;
      else if (w == i) m_cnt[i]--;
      else if (req[i] && m_cnt[i] == MAXC) set[i] = 1'b1;
      else if (req[i]) m_cnt[i]++;
    end
    m_ovf   = set | (m_ovf & ~{N{clr}});
    m_pulse = w >= 0;
    m_busy  = cyc - m_last <= G;
    m_pend  = any;
    cyc++;
  endtask

  task automatic step(input logic [N-1:0] req, input logic en, input logic clr);
    req_pulse = req; enable = en; ovf_clr = clr;
    @(posedge fast_clk);
    model_edge(req, en, clr);
    @(negedge fast_clk);
    chk("pulse", 32'(pulse_fast_out), 32'(m_pulse));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("pending_any", 32'(pending_any), 32'(m_pend));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic en);
    for (int t = 0; t < n; t++) step('0, en, 1'b0);
  endtask

  initial begin
    logic [N-1:0] r;
    @(negedge fast_clk);
    chk("rst_pulse", 32'(pulse_fast_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ovf", 32'(overflow), 0);
    model_reset();
    rst_n = 1'b1;
    // single event
    step(4'b0001, 1'b1, 1'b0);
    idle(12, 1'b1);
    // all four requesters back-to-back
    step(4'b1111, 1'b1, 1'b0);
    idle(40, 1'b1);
    // accumulation on requester 2 while 1 is pending
    step(4'b0010, 1'b1, 1'b0);
    for (int t = 0; t < 3; t++) step(4'b0100, 1'b1, 1'b0);
    idle(40, 1'b1);
    // saturation and overflow
    for (int t = 0; t < 20; t++) step(4'b0001, 1'b1, 1'b0);
    chk("ovf0_set", 32'(overflow[0]), 1);
    step('0, 1'b0, 1'b1);
    chk("ovf0_clr", 32'(overflow[0]), 0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    chk("ovf0_set_wins", 32'(overflow[0]), 1);
    idle(160, 1'b1);
    // enable gating
    step(4'b0011, 1'b0, 1'b0);
    idle(4, 1'b0);
    chk("gated_pending", 32'(pending_any), 1);
    chk("gated_nopulse", 32'(pulse_fast_out), 0);
    step('0, 1'b1, 1'b0);
    chk("resume_pulse", 32'(pulse_fast_out), 1);
    idle(3, 1'b1);
    idle(15, 1'b0);
    chk("midgap_stop", 32'(busy), 0);
    idle(12, 1'b1);
    // reset during a PULSE cycle
    step(4'b0111, 1'b1, 1'b0);
    for (int t = 0; t < 20 && !m_pulse; t++) step('0, 1'b1, 1'b0);
    chk("pre_rst_pulse", 32'(pulse_fast_out), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_pulse", 32'(pulse_fast_out), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_gid", 32'(grant_id), 0);
    chk("arst_pend", 32'(pending_any), 0);
    @(posedge fast_clk);
    @(negedge fast_clk);
    model_reset();
    rst_n = 1'b1;
    idle(12, 1'b1);
    // random traffic
    for (int t = 0; t < 600; t++) begin
      r = '0;
      for (int b = 0; b < N; b++) r[b] = $urandom_range(0, 5) == 0;
      step(r, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
